// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if: decode/writeback bus of the multiport register file.
//   master : drives write port, read addresses, pending mark and clear request
//   slave  : returns read data, per-port pending bits and clear_busy
interface regfile_multiport_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic                           ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0]          ctrl_writeReg;
    logic [DATA_WIDTH-1:0]          data_writeReg;
    logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg;
    logic [NUM_READ*DATA_WIDTH-1:0] data_readReg;
    logic [NUM_READ-1:0]            pending_read;
    logic                           ctrl_markPending;
    logic [ADDR_WIDTH-1:0]          ctrl_pendingReg;
    logic                           ctrl_clear;
    logic                           clear_busy;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
               ctrl_markPending, ctrl_pendingReg, ctrl_clear,
        input  data_readReg, pending_read, clear_busy
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
               ctrl_markPending, ctrl_pendingReg, ctrl_clear,
        output data_readReg, pending_read, clear_busy
    );
endinterface

// File: rtl/regfile_multiport.sv
// regfile_multiport: register file with NUM_READ combinational read ports, one write
// port, optional zero register and write-to-read bypass, per-register pending bits
// and a sequenced bulk clear.
//   clock_i      : clock, all state updates on the rising edge
//   ctrl_reset_i : synchronous active-high reset
//   bus (slave)  : write port, read ports, pending mark/query, clear request/busy
module regfile_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input logic                clock_i,
    input logic                ctrl_reset_i,
    regfile_multiport_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      pend_q;
    logic [DEPTH-1:0]      pend_d;
    logic                  wr_ok;
    logic                  mark_ok;

    assign wr_ok   = bus.ctrl_writeEnable && state_q == IDLE && !(ZERO_REG && bus.ctrl_writeReg == '0);
    assign mark_ok = bus.ctrl_markPending && state_q == IDLE && !(ZERO_REG && bus.ctrl_pendingReg == '0);

    assign bus.clear_busy = state_q == CLEAR;

    // Mark is applied after the write so a same-cycle mark wins over the clear.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (state_q == CLEAR) begin
            mem_d[idx_q]  = '0;
            pend_d[idx_q] = 1'b0;
        end else begin
            if (wr_ok) begin
                mem_d[bus.ctrl_writeReg]  = bus.data_writeReg;
                pend_d[bus.ctrl_writeReg] = 1'b0;
            end
            if (mark_ok) pend_d[bus.ctrl_pendingReg] = 1'b1;
        end
    end

    // wr_ok is already low in CLEAR, so no bypass happens during a clear.
    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit;
        assign ra  = bus.ctrl_readReg[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit = BYPASS && wr_ok && bus.ctrl_writeReg == ra;
        assign bus.data_readReg[i*DATA_WIDTH +: DATA_WIDTH] =
            hit ? bus.data_writeReg : (ZERO_REG && ra == '0) ? '0 : mem_q[ra];
        assign bus.pending_read[i] = hit ? 1'b0 : pend_q[ra];
    end

    always_ff @(posedge clock_i) begin
        if (ctrl_reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
            if (state_q == IDLE) begin
                if (bus.ctrl_clear) begin
                    state_q <= CLEAR;
                    idx_q   <= '0;
                end
            end else if (idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_q <= IDLE;
            end else begin
                idx_q <= idx_q + ADDR_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: checks a default and a reduced configuration against an array model.
module tb_regfile_multiport;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    regfile_multiport_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) ifa ();
    regfile_multiport_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(3)) ifb ();

    regfile_multiport dut_a (.clock_i(clk), .ctrl_reset_i(rst_a), .bus(ifa));
    regfile_multiport #(
        .DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(3), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) dut_b (.clock_i(clk), .ctrl_reset_i(rst_b), .bus(ifb));

    int vectors = 0;
    int miscompares = 0;
    int c;
    logic s_rst, s_we, s_mark, s_clr;
    int s_wa, s_pr;
    int s_ra [4];
    logic [31:0] s_wd;
    logic [31:0] m_mem [2][32];
    logic m_pend [2][32];
    int m_left [2];
    logic obs_busy;

    function automatic int aw(int k); return k != 0 ? 3 : 5; endfunction
    function automatic int depth(int k); return 1 << aw(k); endfunction
    function automatic int nr(int k); return k != 0 ? 3 : 2; endfunction
    function automatic bit zr(int k); return k == 0; endfunction
    function automatic bit byp(int k); return k == 0; endfunction
    function automatic logic [31:0] msk(int k); return k != 0 ? 32'h0000_FFFF : 32'hFFFF_FFFF; endfunction

    function automatic logic [31:0] rd(int i);
        return c != 0 ? 32'(ifb.data_readReg[i*16 +: 16]) : ifa.data_readReg[i*32 +: 32];
    endfunction

    function automatic logic [31:0] rd_pend(int i);
        return c != 0 ? 32'(ifb.pending_read[i]) : 32'(ifa.pending_read[i]);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        s_rst = 0; s_we = 0; s_mark = 0; s_clr = 0;
        s_wa = 0; s_pr = 0; s_wd = '0;
        for (int i = 0; i < 4; i++) s_ra[i] = 0;
    endtask

    task automatic apply();
        if (c == 0) begin
            rst_a = s_rst;
            ifa.ctrl_writeEnable = s_we;
            ifa.ctrl_writeReg    = 5'(s_wa);
            ifa.data_writeReg    = s_wd;
            ifa.ctrl_markPending = s_mark;
            ifa.ctrl_pendingReg  = 5'(s_pr);
            ifa.ctrl_clear       = s_clr;
            for (int i = 0; i < 2; i++) ifa.ctrl_readReg[i*5 +: 5] = 5'(s_ra[i]);
        end else begin
            rst_b = s_rst;
            ifb.ctrl_writeEnable = s_we;
            ifb.ctrl_writeReg    = 3'(s_wa);
            ifb.data_writeReg    = 16'(s_wd);
            ifb.ctrl_markPending = s_mark;
            ifb.ctrl_pendingReg  = 3'(s_pr);
            ifb.ctrl_clear       = s_clr;
            for (int i = 0; i < 3; i++) ifb.ctrl_readReg[i*3 +: 3] = 3'(s_ra[i]);
        end
    endtask

    // One clock: drive, compare outputs against the model, then advance the model at the edge.
    task automatic cycle();
        logic acc, hit;
        int a;
        apply();
        #1;
        obs_busy = c != 0 ? ifb.clear_busy : ifa.clear_busy;
        acc = s_we && m_left[c] == 0 && !(zr(c) && s_wa == 0);
        if (!s_rst) begin
            check($sformatf("c%0d busy", c), 32'(obs_busy), 32'(m_left[c] > 0));
            for (int i = 0; i < nr(c); i++) begin
                a = s_ra[i];
                hit = byp(c) && acc && s_wa == a;
                check($sformatf("c%0d data p%0d r%0d", c, i, a), rd(i), hit ? s_wd : m_mem[c][a]);
                check($sformatf("c%0d pend p%0d r%0d", c, i, a), rd_pend(i), hit ? 32'h0 : 32'(m_pend[c][a]));
            end
        end
        @(posedge clk);
        if (s_rst) begin
            for (int k = 0; k < 32; k++) begin
                m_mem[c][k] = '0;
                m_pend[c][k] = 1'b0;
            end
            m_left[c] = 0;
        end else if (m_left[c] > 0) begin
            a = depth(c) - m_left[c];
            m_mem[c][a] = '0;
            m_pend[c][a] = 1'b0;
            m_left[c]--;
        end else begin
            if (acc) begin
                m_mem[c][s_wa] = s_wd;
                m_pend[c][s_wa] = 1'b0;
            end
            if (s_mark && !(zr(c) && s_pr == 0)) m_pend[c][s_pr] = 1'b1;
            if (s_clr) m_left[c] = depth(c);
        end
        @(negedge clk);
    endtask

    task automatic fill();
        for (int a = 1; a < depth(c); a++) begin
            idle();
            s_we = 1; s_wa = a; s_wd = (32'(a) * 32'h0101_0101 + 32'h11) & msk(c);
            cycle();
        end
        idle();
    endtask

    task automatic scan();
        for (int a = 0; a < depth(c); a++) begin
            idle();
            for (int i = 0; i < 4; i++) s_ra[i] = a;
            cycle();
        end
        idle();
    endtask

    task automatic run_suite();
        int d, n, rk;
        d = depth(c);
        idle(); s_rst = 1; cycle();
        scan();
        s_we = 1; s_wa = 5; s_wd = 32'hDEAD_BEEF & msk(c); s_ra[0] = 5; cycle();
        check("r5 stored", rd(0), 32'hDEAD_BEEF & msk(c));
        idle(); s_we = 1; s_wa = 0; s_wd = 32'h1234; cycle();
        idle(); cycle();
        check("r0 after write", rd(0), zr(c) ? 32'h0 : 32'h1234);
        idle(); s_mark = 1; s_pr = 7; cycle();
        idle(); s_ra[1] = 7; cycle();
        check("r7 pending", rd_pend(1), 32'h1);
        s_we = 1; s_wa = 7; s_wd = 32'h77; cycle();
        idle(); s_ra[1] = 7; cycle();
        check("r7 cleared", rd_pend(1), 32'h0);
        s_we = 1; s_wa = 7; s_wd = 32'h78; s_mark = 1; s_pr = 7; cycle();
        idle(); s_ra[1] = 7; cycle();
        check("r7 set wins", rd_pend(1), 32'h1);
        fill();
        s_clr = 1; cycle();
        n = 0;
        for (int k = 0; k < d + 3; k++) begin
            idle(); s_ra[0] = 3; s_ra[1] = c != 0 ? 5 : 20; s_ra[2] = 1;
            if (k == 4) begin s_we = 1; s_wa = 2; s_wd = 32'hAAAA; end
            cycle();
            n += int'(obs_busy);
        end
        check("busy length", 32'(n), 32'(d));
        idle(); s_ra[0] = 2; cycle();
        check("busy write lost", rd(0), 32'h0);
        fill();
        s_clr = 1; cycle();
        rk = d > 10 ? 10 : 4;
        for (int k = 0; k < rk; k++) begin
            idle(); s_rst = (k == rk - 1); s_ra[0] = d - 1;
            cycle();
        end
        idle(); cycle();
        check("abort busy", 32'(obs_busy), 32'h0);
        scan();
        s_clr = 1; cycle();
        n = 0;
        for (int k = 0; k < d + 4; k++) begin
            idle(); s_clr = (k == 3); s_ra[0] = k % d;
            cycle();
            n += int'(obs_busy);
        end
        check("no restart", 32'(n), 32'(d));
        for (int k = 0; k < 400; k++) begin
            idle();
            s_rst = ($urandom_range(0, 119) == 0);
            s_we = 1'($urandom_range(0, 1));
            s_wa = $urandom_range(0, d - 1);
            s_wd = $urandom & msk(c);
            s_mark = ($urandom_range(0, 2) == 0);
            s_pr = $urandom_range(0, 2) == 0 ? s_wa : $urandom_range(0, d - 1);
            s_clr = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 4; i++) s_ra[i] = $urandom_range(0, d - 1);
            if ($urandom_range(0, 2) == 0) s_ra[0] = s_wa;
            cycle();
        end
        idle(); apply();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0;
            for (int a = 0; a < 32; a++) begin
                m_mem[k][a] = '0;
                m_pend[k][a] = 1'b0;
            end
        end
        idle();
        c = 1; apply();
        c = 0; apply();
        @(negedge clk);
        c = 0; run_suite();
        c = 1; run_suite();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
